spi_reg_rx: RTL and testbench

SPI_REG_RX -- requirements
Module: spi_reg_rx

---
 rtl/spi_reg_rx_pkg.sv | 16 +
 rtl/spi_edge_det.sv | 18 +
 rtl/spi_reg_rx.sv | 173 +++++++++++++++++
 tb/tb_spi_reg_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_rx_pkg.sv
// Shared types and default widths for the SPI register-access receiver.
package spi_reg_rx_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RFETCH,
    RDATA,
    DONE
  } state_e;

endpackage

// File: rtl/spi_edge_det.sv
// Registers the (already reclocked) serial clock and flags its rising edge.
module spi_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sclk_i,
  output logic rise_c
);

  logic sclk_q;

  always_ff @(posedge clk) begin
    if (rst) sclk_q <= 1'b0;
    else     sclk_q <= sclk_i;
  end

  assign rise_c = sclk_i & ~sclk_q;

endmodule

// File: rtl/spi_reg_rx.sv
// SPI slave that turns R/W + address + data frames into register strobes.
// Optional abort counter output enabled by SPI_REG_RX_ABORT_CNT_EN.
module spi_reg_rx
  import spi_reg_rx_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n_i,
  input  logic              sclk_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              busy_o
`ifdef SPI_REG_RX_ABORT_CNT_EN
  ,
  output logic [7:0]        abort_cnt_o
`endif
);

  localparam int unsigned HDR_BITS = ADDR_W + 1;
  localparam int unsigned SR_W     = (DATA_W > ADDR_W) ? DATA_W : ADDR_W + 1;
  localparam int unsigned CNT_W    = $clog2(SR_W + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   sr_q, sr_d, sr_shift;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              we_d, re_d;
  logic              cs_n_q;
  logic              rise_c;

  spi_edge_det u_edge (
    .clk    (clk),
    .rst    (rst),
    .sclk_i (sclk_i),
    .rise_c (rise_c)
  );

  assign sr_shift = {sr_q[SR_W-2:0], mosi_i};

  // Next-state, shift/count and strobe decode; cs_n_i high always wins over an edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    addr_d  = reg_addr_o;
    wdata_d = reg_wdata_o;
    we_d    = 1'b0;
    re_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cs_n_i && cs_n_q) begin
          state_d = ADDR;
          cnt_d   = '0;
        end
      end
      ADDR: begin
        if (cs_n_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (rise_c) begin
          sr_d  = sr_shift;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(HDR_BITS - 1)) begin
            cnt_d  = '0;
            addr_d = sr_shift[ADDR_W-1:0];
            if (sr_shift[ADDR_W]) begin
              state_d = WDATA;
            end else begin
              state_d = RFETCH;
              re_d    = 1'b1;
            end
          end
        end
      end
      WDATA: begin
        if (cs_n_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (rise_c) begin
          sr_d  = sr_shift;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d   = '0;
            wdata_d = sr_shift[DATA_W-1:0];
            we_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      // Strobe cycle, then the cycle in which read data is valid.
      RFETCH: begin
        if (cs_n_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end else begin
          sr_d    = SR_W'(reg_rdata_i);
          cnt_d   = '0;
          state_d = RDATA;
        end
      end
      RDATA: begin
        if (cs_n_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (rise_c) begin
          sr_d  = {sr_q[SR_W-2:0], 1'b0};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (cs_n_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      cs_n_q      <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      reg_we_o    <= 1'b0;
      reg_re_o    <= 1'b0;
      busy_o      <= 1'b0;
      miso_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      cs_n_q      <= cs_n_i;
      reg_addr_o  <= addr_d;
      reg_wdata_o <= wdata_d;
      reg_we_o    <= we_d;
      reg_re_o    <= re_d;
      busy_o      <= (state_d != IDLE);
      miso_o      <= (state_d == RDATA) ? sr_d[DATA_W-1] : 1'b0;
    end
  end

`ifdef SPI_REG_RX_ABORT_CNT_EN
  logic abort_c;

  // DONE -> IDLE on deselect is normal completion, not an abort.
  assign abort_c = cs_n_i && (state_q inside {ADDR, WDATA, RFETCH, RDATA});

  always_ff @(posedge clk) begin
    if (rst)                               abort_cnt_o <= 8'd0;
    else if (abort_c && abort_cnt_o != 8'hFF) abort_cnt_o <= abort_cnt_o + 8'd1;
  end
`endif

endmodule

// File: tb/tb_spi_reg_rx.sv
// Self-checking bench for spi_reg_rx: table of frames, hand-written corner cases, random frames.
module tb_spi_reg_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n_i;
  logic        sclk_i;
  logic        mosi_i;
  logic        miso_o;
  logic [5:0]  reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic        reg_we_o;
  logic        reg_re_o;
  logic [31:0] reg_rdata_i;
  logic        busy_o;
`ifdef SPI_REG_RX_ABORT_CNT_EN
  logic [7:0]  abort_cnt_o;
`endif

  always #5 clk = ~clk;

  spi_reg_rx #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .cs_n_i      (cs_n_i),
    .sclk_i      (sclk_i),
    .mosi_i      (mosi_i),
    .miso_o      (miso_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_we_o    (reg_we_o),
    .reg_re_o    (reg_re_o),
    .reg_rdata_i (reg_rdata_i),
    .busy_o      (busy_o)
`ifdef SPI_REG_RX_ABORT_CNT_EN
    ,
    .abort_cnt_o (abort_cnt_o)
`endif
  );

  typedef struct {
    bit          w;
    logic [5:0]  addr;
    logic [31:0] data;
    int          abort_at;    // bits sent before cs_n rises; 99 = complete frame
    bit          abort_edge;  // cs_n rises together with the final data edge
    int          extra;       // sclk edges sent after the frame, cs still low
  } frame_t;

  int n_vec = 0;
  int n_err = 0;

  // Strobe monitor and read-data responder (data valid only the cycle after reg_re_o).
  int          we_cnt = 0;
  int          re_cnt = 0;
  logic [5:0]  we_addr = '0;
  logic [31:0] we_data = '0;
  logic [5:0]  re_addr = '0;
  logic [31:0] rd_val = '0;
  logic        re_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (reg_we_o) begin
      we_cnt  = we_cnt + 1;
      we_addr = reg_addr_o;
      we_data = reg_wdata_o;
    end
    if (reg_re_o) begin
      re_cnt  = re_cnt + 1;
      re_addr = reg_addr_o;
    end
    reg_rdata_i = re_prev ? rd_val : $urandom;
    re_prev     = reg_re_o;
  end

  // Reference state: what a register slave must show after each frame.
  logic [5:0]  m_addr = '0;
  logic [31:0] m_wdata = '0;
  int          m_abort = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, 64'(busy_o), 64'd0);
    check({tag, " miso"}, 64'(miso_o), 64'd0);
    check({tag, " addr"}, 64'(reg_addr_o), 64'(m_addr));
    check({tag, " wdata"}, 64'(reg_wdata_o), 64'(m_wdata));
`ifdef SPI_REG_RX_ABORT_CNT_EN
    check({tag, " abort_cnt"}, 64'(abort_cnt_o), 64'(m_abort));
`endif
  endtask

  // One sclk period (5 clk low, 5 clk high); miso sampled just before the rise.
  task automatic sclk_bit(input logic b, input bit cs_with_edge, output logic m);
    sclk_i = 1'b0;
    mosi_i = b;
    repeat (5) @(negedge clk);
    m      = miso_o;
    sclk_i = 1'b1;
    if (cs_with_edge) cs_n_i = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input frame_t f);
    logic [38:0] bits;
    logic [31:0] rd_word;
    logic        m;
    int          we0, re0, h;
    bit          exp_we, exp_re;
    logic [31:0] payload;
    payload = f.w ? f.data : 32'($urandom);
    bits    = {f.w, f.addr, payload};
    rd_word = '0;
    we0     = we_cnt;
    re0     = re_cnt;
    rd_val  = f.data;
    cs_n_i  = 1'b0;
    for (int i = 0; i < 39; i++) begin
      if (f.abort_at == i) break;
      sclk_bit(bits[38-i], f.abort_edge && (i == 38), m);
      if (i >= 7) rd_word = {rd_word[30:0], m};
    end
    for (int i = 0; i < f.extra; i++) sclk_bit(1'($urandom), 1'b0, m);
    sclk_i = 1'b0;
    cs_n_i = 1'b1;
    repeat (4) @(negedge clk);

    // Bits the slave honours; an edge coincident with deselect does not count.
    h = f.abort_edge ? 38 : ((f.abort_at < 39) ? f.abort_at : 39);
    exp_we = f.w && (h == 39);
    exp_re = !f.w && (h >= 7);
    if (h >= 7) m_addr = f.addr;
    if (exp_we) m_wdata = f.data;
    if (h < 39) m_abort = (m_abort < 255) ? m_abort + 1 : 255;

    check({tag, " we pulses"}, 64'(we_cnt - we0), 64'(exp_we));
    check({tag, " re pulses"}, 64'(re_cnt - re0), 64'(exp_re));
    if (exp_we) begin
      check({tag, " we addr"}, 64'(we_addr), 64'(f.addr));
      check({tag, " we data"}, 64'(we_data), 64'(f.data));
    end
    if (exp_re) check({tag, " re addr"}, 64'(re_addr), 64'(f.addr));
    if (!f.w && h == 39) check({tag, " miso word"}, 64'(rd_word), 64'(f.data));
    check_idle_outputs(tag);
  endtask

  frame_t tbl [9];
  frame_t rf;
  logic   m;
  int     we0;

  initial begin
    tbl[0] = '{1'b1, 6'h05, 32'hDEADBEEF, 99, 1'b0, 0};
    tbl[1] = '{1'b0, 6'h2A, 32'h12345678, 99, 1'b0, 0};
    tbl[2] = '{1'b1, 6'h15, 32'h0BADF00D, 10, 1'b0, 0};
    tbl[3] = '{1'b1, 6'h11, 32'hCAFEF00D, 99, 1'b0, 0};
    tbl[4] = '{1'b1, 6'h3F, 32'hA5A5A5A5, 99, 1'b0, 5};
    tbl[5] = '{1'b1, 6'h00, 32'h87654321, 99, 1'b1, 0};
    tbl[6] = '{1'b0, 6'h01, 32'h80000001, 99, 1'b0, 3};
    tbl[7] = '{1'b0, 6'h3F, 32'hFFFFFFFF, 20, 1'b0, 0};
    tbl[8] = '{1'b1, 6'h3F, 32'h00000000, 99, 1'b0, 0};

    rst    = 1'b1;
    cs_n_i = 1'b1;
    sclk_i = 1'b0;
    mosi_i = 1'b0;
    reg_rdata_i = '0;
    repeat (3) @(negedge clk);
    check("reset we", 64'(reg_we_o), 64'd0);
    check("reset re", 64'(reg_re_o), 64'd0);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 9; i++) run_frame($sformatf("tbl%0d", i), tbl[i]);

    // Reset 20 bits into a write: frame discarded, outputs cleared, cs must cycle.
    we0    = we_cnt;
    cs_n_i = 1'b0;
    for (int i = 0; i < 20; i++) sclk_bit(1'b1, 1'b0, m);
    sclk_i = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_abort = 0;
    check("rst we", 64'(reg_we_o), 64'd0);
    check("rst re", 64'(reg_re_o), 64'd0);
    check_idle_outputs("rst");
    for (int i = 0; i < 25; i++) sclk_bit(1'b1, 1'b0, m);
    sclk_i = 1'b0;
    check("rst no start we", 64'(we_cnt - we0), 64'd0);
    check("rst no start busy", 64'(busy_o), 64'd0);
    cs_n_i = 1'b1;
    repeat (4) @(negedge clk);
    run_frame("post-rst", '{1'b1, 6'h2C, 32'h13579BDF, 99, 1'b0, 0});

    for (int i = 0; i < 20; i++) begin
      rf.w          = 1'($urandom);
      rf.addr       = 6'($urandom);
      rf.data       = $urandom;
      rf.abort_at   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 38)) : 99;
      rf.abort_edge = 1'b0;
      rf.extra      = int'($urandom_range(0, 2));
      run_frame($sformatf("rnd%0d", i), rf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
